// File: rtl/cipher_byte_scheduler.sv
// -----------------------------------------------------------------------------
// cipher_byte_scheduler
//
// Byte-level controller for the dual XOR stream cipher core.
//   * Loads a parallel LFSR configuration word into the core's serial cfg chain,
//     MSB first, then waits SETTLE idle cycles before reporting "configured".
//   * Arbitrates TX (encrypt) and RX (decrypt) byte requests round-robin.
//   * Serialises each granted byte LSB-first into single-cycle bit strobes
//     spaced GAP idle cycles apart, and collects the core's combinational
//     response bit on the same clock edge as each strobe.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_start, cfg_word   config load request and word (sampled on accept)
//   cfg_busy, configured  shifting/settling indicator, sticky "config done"
//   tx_req/tx_byte        encrypt request and plaintext
//   tx_ack/tx_done/tx_out grant pulse, completion pulse, ciphertext
//   rx_*                  same as tx_*, decrypt path
//   cc_cfg_en/cc_cfg_i    core config chain enable and serial data
//   cc_tx_en/cc_tx_p/cc_tx_e  core encrypt strobe, plaintext bit, cipher bit
//   cc_rx_en/cc_rx_e/cc_rx_p  core decrypt strobe, cipher bit, plaintext bit
//   dbg_state             current FSM state
//
// Handshake: a request (tx_req / rx_req) is a level that the host holds until
// the matching 1-cycle ack. The byte is captured on the clock edge that ends
// the ack cycle; dropping the request before ack withdraws it, and changes to
// the byte after ack have no effect. *_done pulses for one cycle with *_out
// valid; *_out then holds until the next *_done of the same path.
// -----------------------------------------------------------------------------
module cipher_byte_scheduler #(
  parameter int M      = 32,
  parameter int W      = 8,
  parameter int GAP    = 1,
  parameter int SETTLE = 2,
  localparam int CFG_LEN = 2 * M + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  // configuration
  input  logic               cfg_start,
  input  logic [CFG_LEN-1:0] cfg_word,
  output logic               cfg_busy,
  output logic               configured,
  // encrypt path
  input  logic               tx_req,
  input  logic [W-1:0]       tx_byte,
  output logic               tx_ack,
  output logic               tx_done,
  output logic [W-1:0]       tx_out,
  // decrypt path
  input  logic               rx_req,
  input  logic [W-1:0]       rx_byte,
  output logic               rx_ack,
  output logic               rx_done,
  output logic [W-1:0]       rx_out,
  // cipher core interface
  output logic               cc_cfg_en,
  output logic               cc_cfg_i,
  output logic               cc_tx_en,
  output logic               cc_tx_p,
  input  logic               cc_tx_e,
  output logic               cc_rx_en,
  output logic               cc_rx_e,
  input  logic               cc_rx_p,
  // debug
  output logic [2:0]         dbg_state
);

  localparam int CNT_MAX = (CFG_LEN > GAP) ? ((CFG_LEN > SETTLE) ? CFG_LEN : SETTLE)
                                           : ((GAP > SETTLE) ? GAP : SETTLE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(W);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CFG_SHIFT  = 3'd1;
  localparam logic [2:0] S_CFG_SETTLE = 3'd2;
  localparam logic [2:0] S_BIT        = 3'd3;
  localparam logic [2:0] S_GAP_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]         state;
  logic               path_rx;     // path of the byte in flight: 0 = TX, 1 = RX
  logic               prefer_rx;   // set when TX was granted last
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [CFG_LEN-1:0] cfg_sr;
  // Holds the not-yet-strobed bits; bit 0 of the byte goes straight onto the
  // data line at grant, so only W-1 bits need storing.
  logic [W-2:0]       data_sr;
  logic [W-1:0]       res_sr;
  logic [W-1:0]       res_next;

  logic in_idle;
  logic cfg_accept;
  logic can_grant;
  logic grant_tx;
  logic grant_rx;
  logic core_bit;
  logic last_bit;

  // ---------------------------------------------------------------------------
  // Arbitration: config load beats byte grants; bytes only once configured.
  // When both paths request, the one not granted last wins.
  // ---------------------------------------------------------------------------
  assign in_idle    = (state == S_IDLE);
  assign cfg_accept = in_idle && cfg_start;
  assign can_grant  = in_idle && !cfg_start && configured;
  assign grant_tx   = can_grant && tx_req && (!rx_req || !prefer_rx);
  assign grant_rx   = can_grant && rx_req && (!tx_req ||  prefer_rx);

  assign tx_ack = grant_tx;
  assign rx_ack = grant_rx;

  assign cfg_busy  = (state == S_CFG_SHIFT) || (state == S_CFG_SETTLE);
  assign cc_cfg_en = (state == S_CFG_SHIFT);
  assign cc_cfg_i  = cc_cfg_en && cfg_sr[CFG_LEN-1];

  assign cc_tx_en = (state == S_BIT) && !path_rx;
  assign cc_rx_en = (state == S_BIT) &&  path_rx;
  assign tx_done  = (state == S_DONE) && !path_rx;
  assign rx_done  = (state == S_DONE) &&  path_rx;

  assign dbg_state = state;

  // Core response is combinational in the strobe cycle.
  assign core_bit = path_rx ? cc_rx_p : cc_tx_e;
  assign last_bit = (bit_cnt == BIT_W'(W - 1));

  always_comb begin
    res_next          = res_sr;
    res_next[bit_cnt] = core_bit;
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      path_rx    <= 1'b0;
      prefer_rx  <= 1'b0;
      cnt        <= '0;
      bit_cnt    <= '0;
      cfg_sr     <= '0;
      data_sr    <= '0;
      res_sr     <= '0;
      configured <= 1'b0;
      tx_out     <= '0;
      rx_out     <= '0;
      cc_tx_p    <= 1'b0;
      cc_rx_e    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_accept) begin
            cfg_sr <= cfg_word;
            cnt    <= '0;
            state  <= S_CFG_SHIFT;
          end else if (grant_tx || grant_rx) begin
            path_rx   <= grant_rx;
            prefer_rx <= grant_tx;
            bit_cnt   <= '0;
            res_sr    <= '0;
            state     <= S_BIT;
            if (grant_rx) begin
              data_sr <= rx_byte[W-1:1];
              cc_rx_e <= rx_byte[0];
            end else begin
              data_sr <= tx_byte[W-1:1];
              cc_tx_p <= tx_byte[0];
            end
          end
        end

        S_CFG_SHIFT: begin
          cfg_sr <= cfg_sr << 1;
          if (cnt == CNT_W'(CFG_LEN - 1)) begin
            cnt <= '0;
            if (SETTLE == 0) begin
              configured <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state <= S_CFG_SETTLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_CFG_SETTLE: begin
          if (cnt == CNT_W'(SETTLE - 1)) begin
            cnt        <= '0;
            configured <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BIT: begin
          res_sr <= res_next;
          if (last_bit) begin
            if (path_rx) rx_out <= res_next;
            else         tx_out <= res_next;
            state <= S_DONE;
          end else if (GAP == 0) begin
            // Back-to-back strobes: present the next bit immediately.
            bit_cnt <= bit_cnt + 1'b1;
            data_sr <= data_sr >> 1;
            if (path_rx) cc_rx_e <= data_sr[0];
            else         cc_tx_p <= data_sr[0];
          end else begin
            cnt   <= '0;
            state <= S_GAP_WAIT;
          end
        end

        S_GAP_WAIT: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            data_sr <= data_sr >> 1;
            if (path_rx) cc_rx_e <= data_sr[0];
            else         cc_tx_p <= data_sr[0];
            state   <= S_BIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_byte_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cipher_byte_scheduler
//
// Directed bench for cipher_byte_scheduler with a small behavioural cipher core:
// the config chain is {tx_lfsr[31:0], rx_lfsr[31:0], mode[1:0]}, each LFSR
// shifts right on its strobe and the keystream bit is lfsr[0], so the first
// 16 keystream bits of either path are simply seed[15:0].
// With seed 32'h1234C3A5: keystream bytes are A5 then C3.
// -----------------------------------------------------------------------------
module tb_cipher_byte_scheduler;

  localparam int M       = 32;
  localparam int W       = 8;
  localparam int CFG_LEN = 2 * M + 2;
  localparam logic [CFG_LEN-1:0] CFG_W0 = {32'h1234C3A5, 32'h1234C3A5, 2'b00};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic               cfg_start;
  logic [CFG_LEN-1:0] cfg_word;
  logic               cfg_busy, configured;
  logic               tx_req, tx_ack, tx_done;
  logic [W-1:0]       tx_byte, tx_out;
  logic               rx_req, rx_ack, rx_done;
  logic [W-1:0]       rx_byte, rx_out;
  logic               cc_cfg_en, cc_cfg_i;
  logic               cc_tx_en, cc_tx_p, cc_tx_e;
  logic               cc_rx_en, cc_rx_e, cc_rx_p;
  logic [2:0]         dbg_state;

  cipher_byte_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_word   (cfg_word),
    .cfg_busy   (cfg_busy),
    .configured (configured),
    .tx_req     (tx_req),
    .tx_byte    (tx_byte),
    .tx_ack     (tx_ack),
    .tx_done    (tx_done),
    .tx_out     (tx_out),
    .rx_req     (rx_req),
    .rx_byte    (rx_byte),
    .rx_ack     (rx_ack),
    .rx_done    (rx_done),
    .rx_out     (rx_out),
    .cc_cfg_en  (cc_cfg_en),
    .cc_cfg_i   (cc_cfg_i),
    .cc_tx_en   (cc_tx_en),
    .cc_tx_p    (cc_tx_p),
    .cc_tx_e    (cc_tx_e),
    .cc_rx_en   (cc_rx_en),
    .cc_rx_e    (cc_rx_e),
    .cc_rx_p    (cc_rx_p),
    .dbg_state  (dbg_state)
  );

  // ---------------- behavioural cipher core ----------------
  logic [CFG_LEN-1:0] core_chain = '0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[0] ^ s[1] ^ s[21] ^ s[31], s[31:1]};
  endfunction

  always @(posedge clk) begin
    if (cc_cfg_en) begin
      core_chain <= {core_chain[CFG_LEN-2:0], cc_cfg_i};
    end else begin
      if (cc_tx_en) core_chain[65:34] <= lfsr_next(core_chain[65:34]);
      if (cc_rx_en) core_chain[33:2]  <= lfsr_next(core_chain[33:2]);
    end
  end

  assign cc_tx_e = cc_tx_p ^ core_chain[34];
  assign cc_rx_p = cc_rx_e ^ core_chain[2];

  // ---------------- scoreboard state ----------------
  int           tests_run = 0;
  int           tests_failed = 0;
  int           viol = 0;
  logic [W-1:0] exp_q[$];

  // Strobe exclusivity monitor.
  always @(negedge clk) begin
    if (rst_n && ((cc_tx_en && cc_rx_en) || (cc_cfg_en && (cc_tx_en || cc_rx_en))))
      viol <= viol + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_word  = '0;
    tx_req    = 1'b0;
    tx_byte   = '0;
    rx_req    = 1'b0;
    rx_byte   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Loads a config. Returns at the first negedge after cfg_busy falls.
  // With repulse set, a second cfg_start with an all-ones word is issued mid-shift.
  task automatic run_cfg(input logic [CFG_LEN-1:0] word, input bit repulse,
                         output bit ok, output int en_cycles, output int busy_cycles,
                         output logic [CFG_LEN-1:0] shifted);
    bit seen_busy;
    ok = 0; en_cycles = 0; busy_cycles = 0; shifted = '0; seen_busy = 0;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_word  = word;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cc_cfg_en) begin
        en_cycles++;
        shifted = {shifted[CFG_LEN-2:0], cc_cfg_i};
      end
      if (cfg_busy) begin
        busy_cycles++;
        seen_busy = 1;
      end
      if (seen_busy && !cfg_busy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      cfg_start = repulse && (i == 10);
      cfg_word  = (repulse && i == 10) ? '1 : word;
    end
    cfg_start = 1'b0;
  endtask

  // Requests one byte on a path and follows it to done.
  task automatic xfer(input bit rx, input logic [W-1:0] b, output bit ok,
                      output logic [W-1:0] out, output int lat,
                      output logic [15:0] smap, output logic [W-1:0] pbits);
    int t_ack;
    int k;
    t_ack = -1; k = 0; ok = 0; out = '0; lat = -1; smap = '0; pbits = '0;
    @(posedge clk); #1;
    if (rx) begin rx_req = 1'b1; rx_byte = b; end
    else    begin tx_req = 1'b1; tx_byte = b; end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (t_ack < 0) begin
        if (rx ? rx_ack : tx_ack) t_ack = cyc;
      end else begin
        if (rx ? cc_rx_en : cc_tx_en) begin
          if (cyc - t_ack < 16) smap[cyc - t_ack] = 1'b1;
          if (k < W) pbits[k] = rx ? cc_rx_e : cc_tx_p;
          k++;
        end
        if (rx ? rx_done : tx_done) begin
          lat = cyc - t_ack;
          out = rx ? rx_out : tx_out;
          ok  = 1;
          break;
        end
      end
      @(posedge clk); #1;
      if (t_ack >= 0) begin
        // After ack the request is dropped and the byte scrambled.
        if (rx) begin rx_req = 1'b0; rx_byte = ~b; end
        else    begin tx_req = 1'b0; tx_byte = ~b; end
      end
    end
    tx_req = 1'b0;
    rx_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({cfg_busy, configured, tx_ack, tx_done, tx_out, rx_ack, rx_done, rx_out,
         cc_cfg_en, cc_cfg_i, cc_tx_en, cc_tx_p, cc_rx_en, cc_rx_e} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got nonzero outputs tx_out=%0h rx_out=%0h busy=%0b cfgd=%0b",
               tx_out, rx_out, cfg_busy, configured);
    end
    tests_run++;
    if (dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_config();
    bit ok; int en, busy; logic [CFG_LEN-1:0] sh;
    do_reset();
    run_cfg('0, 1'b1, ok, en, busy, sh);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL cfg_timeout: got %0b expected 1", ok); end
    tests_run++;
    if (en !== 66) begin tests_failed++; $display("FAIL cfg_en_cycles: got %0d expected 66", en); end
    tests_run++;
    if (sh !== '0) begin tests_failed++; $display("FAIL cfg_i_zero: got %0h expected 0", sh); end
    tests_run++;
    if (busy !== 68) begin tests_failed++; $display("FAIL cfg_busy_cycles: got %0d expected 68", busy); end
    tests_run++;
    if (configured !== 1'b1) begin tests_failed++; $display("FAIL cfg_configured: got %0b expected 1", configured); end
  endtask

  task automatic test_req_before_config();
    bit ok; int en, busy, acks; logic [CFG_LEN-1:0] sh;
    do_reset();
    @(posedge clk); #1;
    tx_req = 1'b1; tx_byte = 8'hF0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_ack) acks++;
    end
    tests_run++;
    if (acks !== 0) begin tests_failed++; $display("FAIL unconfigured_ack: got %0d acks expected 0", acks); end
    run_cfg(CFG_W0, 1'b0, ok, en, busy, sh);
    // run_cfg returns in the first IDLE cycle with configured high.
    tests_run++;
    if ({ok, configured, tx_ack} !== 3'b111) begin
      tests_failed++;
      $display("FAIL ack_after_cfg: got ok/configured/ack=%b expected 111", {ok, configured, tx_ack});
    end
    tests_run++;
    if (sh !== CFG_W0) begin tests_failed++; $display("FAIL cfg_bits: got %0h expected %0h", sh, CFG_W0); end
    @(posedge clk); #1 tx_req = 1'b0;
  endtask

  task automatic test_encrypt();
    bit ok; int en, busy, lat; logic [CFG_LEN-1:0] sh; logic [W-1:0] out, pb; logic [15:0] sm;
    do_reset();
    run_cfg(CFG_W0, 1'b0, ok, en, busy, sh);
    xfer(1'b0, 8'hF0, ok, out, lat, sm, pb);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL enc_timeout: got %0b expected 1", ok); end
    tests_run++;
    if (sm !== 16'hAAAA) begin tests_failed++; $display("FAIL enc_strobe_map: got %0h expected aaaa", sm); end
    tests_run++;
    if (pb !== 8'hF0) begin tests_failed++; $display("FAIL enc_p_bits: got %0h expected f0", pb); end
    tests_run++;
    if (lat !== 16) begin tests_failed++; $display("FAIL enc_done_latency: got %0d expected 16", lat); end
    tests_run++;
    if (out !== 8'h55) begin tests_failed++; $display("FAIL enc_tx_out: got %0h expected 55", out); end
  endtask

  task automatic test_round_trip();
    bit ok; int en, busy, lat; logic [CFG_LEN-1:0] sh; logic [W-1:0] c0, c1, out, pb; logic [15:0] sm;
    do_reset();
    run_cfg(CFG_W0, 1'b0, ok, en, busy, sh);
    xfer(1'b0, 8'hF0, ok, c0, lat, sm, pb);
    xfer(1'b0, 8'h0F, ok, c1, lat, sm, pb);
    tests_run++;
    if (c1 !== 8'hCC) begin tests_failed++; $display("FAIL rt_cipher1: got %0h expected cc", c1); end
    do_reset();
    run_cfg(CFG_W0, 1'b0, ok, en, busy, sh);
    xfer(1'b1, c0, ok, out, lat, sm, pb);
    tests_run++;
    if (out !== 8'hF0) begin tests_failed++; $display("FAIL rt_plain0: got %0h expected f0", out); end
    tests_run++;
    if (sm !== 16'hAAAA || lat !== 16) begin
      tests_failed++;
      $display("FAIL rt_rx_timing: got map %0h lat %0d expected aaaa 16", sm, lat);
    end
    xfer(1'b1, c1, ok, out, lat, sm, pb);
    tests_run++;
    if (out !== 8'h0F) begin tests_failed++; $display("FAIL rt_plain1: got %0h expected 0f", out); end
  endtask

  task automatic test_back_to_back();
    bit ok; int en, busy, grants, dones; logic [CFG_LEN-1:0] sh;
    logic [3:0] order; int ack_cyc[4]; logic [W-1:0] exp_v, got_v;
    do_reset();
    run_cfg(CFG_W0, 1'b0, ok, en, busy, sh);
    exp_q.delete();
    exp_q.push_back(8'h55);  // TX F0 ^ A5
    exp_q.push_back(8'hF0);  // RX 55 ^ A5
    exp_q.push_back(8'h33);  // TX F0 ^ C3
    exp_q.push_back(8'h96);  // RX 55 ^ C3
    grants = 0; dones = 0; order = '0;
    @(posedge clk); #1;
    tx_req = 1'b1; tx_byte = 8'hF0;
    rx_req = 1'b1; rx_byte = 8'h55;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((tx_ack || rx_ack) && grants < 4) begin
        order[grants]   = rx_ack;
        ack_cyc[grants] = cyc;
        grants++;
      end
      if (tx_done || rx_done) begin
        got_v = tx_done ? tx_out : rx_out;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tests_run++;
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL b2b_out%0d: got %0h expected %0h", dones, got_v, exp_v);
        end
        dones++;
        if (dones == 4) break;
      end
      @(posedge clk); #1;
      if (grants >= 4) begin tx_req = 1'b0; rx_req = 1'b0; end
    end
    tx_req = 1'b0; rx_req = 1'b0;
    tests_run++;
    if (dones !== 4) begin tests_failed++; $display("FAIL b2b_count: got %0d dones expected 4", dones); end
    tests_run++;
    if (order !== 4'b1010) begin tests_failed++; $display("FAIL b2b_order: got %b expected 1010", order); end
    tests_run++;
    if (ack_cyc[1] - ack_cyc[0] !== 17 || ack_cyc[2] - ack_cyc[1] !== 17 || ack_cyc[3] - ack_cyc[2] !== 17) begin
      tests_failed++;
      $display("FAIL b2b_ack_spacing: got %0d %0d %0d expected 17 17 17",
               ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1], ack_cyc[3] - ack_cyc[2]);
    end
    tests_run++;
    if (viol !== 0) begin tests_failed++; $display("FAIL strobe_overlap: got %0d expected 0", viol); end
  endtask

  task automatic test_reset_mid_byte();
    bit ok, acked, hit; int en, busy, k, acks, dones; logic [CFG_LEN-1:0] sh;
    do_reset();
    run_cfg(CFG_W0, 1'b0, ok, en, busy, sh);
    @(posedge clk); #1;
    tx_req = 1'b1; tx_byte = 8'hF0;
    acked = 0; hit = 0; k = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_ack) acked = 1;
      if (cc_tx_en) begin
        if (k == 4) begin
          rst_n = 1'b0;
          #1;
          hit = 1;
          tests_run++;
          if ({cc_cfg_en, cc_cfg_i, cc_tx_en, cc_tx_p, cc_rx_en, cc_rx_e} !== 6'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_cc: got %b expected 000000",
                     {cc_cfg_en, cc_cfg_i, cc_tx_en, cc_tx_p, cc_rx_en, cc_rx_e});
          end
          tests_run++;
          if (configured !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_configured: got %0b expected 0", configured); end
          break;
        end
        k++;
      end
      @(posedge clk); #1;
      if (acked) tx_req = 1'b0;
    end
    tests_run++;
    if (hit !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_reached: got %0b expected 1", hit); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tx_req = 1'b1;
    acks = 0; dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_ack)  acks++;
      if (tx_done) dones++;
    end
    tests_run++;
    if (acks !== 0 || dones !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_quiet: got acks %0d dones %0d expected 0 0", acks, dones);
    end
    run_cfg(CFG_W0, 1'b0, ok, en, busy, sh);
    tests_run++;
    if (tx_ack !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_regrant: got %0b expected 1", tx_ack); end
    @(posedge clk); #1 tx_req = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cyc = 0;
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_word = '0;
    tx_req = 1'b0; tx_byte = '0;
    rx_req = 1'b0; rx_byte = '0;
    test_reset();
    test_config();
    test_req_before_config();
    test_encrypt();
    test_round_trip();
    test_back_to_back();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
